// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported unified memory between the IF-stage fetch port
// and the MEM-stage load/store port. Each access is sequenced over a
// request/ack handshake to the backing RAM. Read data returns to the
// requester through a registered data bus and a one-cycle ready pulse.
// MEM normally wins a simultaneous request. A starvation counter hands the
// grant to IF after STARVE_LIM MEM grants that were made while IF was
// waiting.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              reset,
  // fetch port
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  // load/store port
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  // backing RAM
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  input  logic              ram_ack,
  // hazard unit
  output logic              stall_if,
  output logic              stall_mem
);

  // Counter width is wide enough to hold STARVE_LIM itself.
  // A limit below 1 still gets a 1-bit counter.
  localparam int CNT_W = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIM);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_IF,
    BUSY_MEM
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;

  logic if_elig;
  logic mem_elig;
  logic grant_if;
  logic grant_mem;

  // A request seen during its own ready pulse is the old, already-served
  // request still being held. It is not allowed to win another grant.
  assign if_elig  = if_req & ~if_ready;
  assign mem_elig = (mem_rd | mem_wr) & ~mem_ready;

  // MEM has priority. IF wins when it is alone, or when MEM has been
  // favoured STARVE_LIM times in a row while IF was waiting.
  assign grant_if  = if_elig & (~mem_elig | (starve_cnt == CNT_MAX));
  assign grant_mem = mem_elig & ~grant_if;

  assign stall_if  = if_req & ~if_ready;
  assign stall_mem = (mem_rd | mem_wr) & ~mem_ready;

  // Arbitration FSM: grant in IDLE, hold the RAM strobe until ack, then pulse ready.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_if) begin
            state      <= BUSY_IF;
            ram_addr   <= if_addr;
            ram_we     <= 1'b0;
            ram_en     <= 1'b1;
            starve_cnt <= '0;
          end else if (grant_mem) begin
            state    <= BUSY_MEM;
            ram_addr <= mem_addr;
            ram_en   <= 1'b1;
            // A request with both mem_rd and mem_wr high is served as a store.
            if (mem_wr) begin
              ram_we    <= 1'b1;
              ram_wdata <= mem_wdata;
            end else begin
              ram_we <= 1'b0;
            end
            if (if_elig && (starve_cnt != CNT_MAX)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end
        end
        BUSY_IF: begin
          if (ram_ack) begin
            if_rdata <= ram_rdata;
            if_ready <= 1'b1;
            ram_en   <= 1'b0;
            ram_we   <= 1'b0;
            state    <= IDLE;
          end
        end
        BUSY_MEM: begin
          if (ram_ack) begin
            // A completed store leaves mem_rdata unchanged.
            if (!ram_we) begin
              mem_rdata <= ram_rdata;
            end
            mem_ready <= 1'b1;
            ram_en    <= 1'b0;
            ram_we    <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          ram_en <= 1'b0;
          ram_we <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Self-checking bench for mem_port_arbiter with a behavioural RAM that has a
// programmable ack delay. Expected read data is queued per port when a
// request is driven. The queued value is compared when that port's ready
// pulse appears.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        ram_en;
  logic        ram_we;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        ram_ack;
  logic        stall_if;
  logic        stall_mem;

  // RAM model state
  logic        model_ack = 1'b0;
  logic [31:0] model_rdata = '1;
  logic        inject_ack = 1'b0;
  int          ram_delay = 0;
  int          wait_cnt = 0;
  logic [31:0] ram_store [logic [31:0]];

  int          checks = 0;
  int          errors = 0;
  logic [31:0] if_q[$];
  logic [31:0] mem_q[$];
  logic [31:0] exp_mem = '0;

  typedef struct {
    bit          is_if;
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;
    logic [31:0] exp_rdata;
    bit          exp_we;
  } vec_t;

  vec_t vecs[7];

  assign ram_ack   = model_ack | inject_ack;
  assign ram_rdata = inject_ack ? 32'h7777_7777 : model_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIM(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .ram_ack(ram_ack),
    .stall_if(stall_if), .stall_mem(stall_mem)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  function automatic logic [31:0] lookup(input logic [31:0] a);
    if (ram_store.exists(a)) return ram_store[a];
    return 32'hBAD0_0000 ^ a;
  endfunction

  // Behavioural RAM: acks ram_delay cycles after ram_en first rises, commits stores on ack
  always begin
    @(posedge clk);
    #1;
    if (ram_en && !reset) begin
      if (wait_cnt == ram_delay) begin
        if (ram_we) ram_store[ram_addr] = ram_wdata;
        model_rdata = lookup(ram_addr);
        model_ack   = 1'b1;
        wait_cnt    = 0;
      end else begin
        model_ack   = 1'b0;
        model_rdata = '1;
        wait_cnt++;
      end
    end else begin
      model_ack   = 1'b0;
      model_rdata = '1;
      wait_cnt    = 0;
    end
  end

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h want %h", name, actual, expected);
    end
  endtask

  // Scoreboard: every ready pulse must match the oldest expected value of its port
  always @(negedge clk) begin
    if (if_ready === 1'b1) begin
      if (if_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL if_ready_unexpected: got pulse want none");
      end else begin
        check_output("if_rdata", if_rdata, if_q.pop_front());
      end
    end
    if (mem_ready === 1'b1) begin
      if (mem_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL mem_ready_unexpected: got pulse want none");
      end else begin
        check_output("mem_rdata", mem_rdata, mem_q.pop_front());
      end
    end
  end

  // Drives one single-port access and waits (bounded) for its ready pulse
  task automatic apply_stimulus(input vec_t v, output int en_cycles,
                                output logic [31:0] first_addr,
                                output logic first_we, output bit got_ready);
    bit seen;
    seen       = 1'b0;
    en_cycles  = 0;
    got_ready  = 1'b0;
    first_addr = '0;
    first_we   = 1'b0;
    ram_delay  = v.delay;
    @(negedge clk);
    if (v.is_if) begin
      if_req  = 1'b1;
      if_addr = v.addr;
      if_q.push_back(v.exp_rdata);
    end else begin
      mem_rd    = v.rd;
      mem_wr    = v.wr;
      mem_addr  = v.addr;
      mem_wdata = v.wdata;
      mem_q.push_back(v.exp_rdata);
    end
    for (int cyc = 0; cyc < 40 && !got_ready; cyc++) begin
      @(negedge clk);
      if (ram_en) begin
        if (!seen) begin
          first_addr = ram_addr;
          first_we   = ram_we;
          seen       = 1'b1;
        end
        en_cycles++;
      end
      if (v.is_if ? if_ready : mem_ready) begin
        got_ready = 1'b1;
        check_output("stall_in_ready_cycle", 32'(v.is_if ? stall_if : stall_mem), 32'd0);
      end else begin
        check_output("stall_while_waiting", 32'(v.is_if ? stall_if : stall_mem), 32'd1);
      end
    end
    if_req = 1'b0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    if (!got_ready) $display("[TB] FAIL ready_timeout: got no ready want pulse");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          en_cycles;
    logic [31:0] first_addr;
    logic        first_we;
    bit          got_ready;
    vec_t        v;

    //            is_if rd    wr    addr          wdata         dly exp           we
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0040, 32'h0,        0, 32'h2108_0001, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0000_0200, 32'hCAFE_F00D, 1, 32'h0000_0000, 1'b1};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0000_0200, 32'h0,        2, 32'hCAFE_F00D, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0,        0, 32'hCAFE_F00D, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0000_0044, 32'h0,        3, 32'h2108_0002, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0000_0044, 32'h5555_AAAA, 0, 32'h2108_0002, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0044, 32'h0,        1, 32'h5555_AAAA, 1'b0};

    ram_store[32'h40]  = 32'h2108_0001;
    ram_store[32'h44]  = 32'h2108_0002;
    ram_store[32'h500] = 32'h0000_1234;

    // Reset state
    repeat (2) @(negedge clk);
    check_output("rst_ram_en", 32'(ram_en), 32'd0);
    check_output("rst_ram_we", 32'(ram_we), 32'd0);
    check_output("rst_if_ready", 32'(if_ready), 32'd0);
    check_output("rst_mem_ready", 32'(mem_ready), 32'd0);
    check_output("rst_if_rdata", if_rdata, 32'd0);
    check_output("rst_mem_rdata", mem_rdata, 32'd0);
    check_output("rst_ram_addr", ram_addr, 32'd0);
    check_output("rst_ram_wdata", ram_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_output("idle_stall_if", 32'(stall_if), 32'd0);
    check_output("idle_stall_mem", 32'(stall_mem), 32'd0);

    // Table-driven single-port accesses
    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      apply_stimulus(v, en_cycles, first_addr, first_we, got_ready);
      check_output("vec_ready_seen", 32'(got_ready), 32'd1);
      check_output("vec_en_cycles", 32'(en_cycles), 32'(v.delay + 1));
      check_output("vec_ram_addr", first_addr, v.addr);
      check_output("vec_ram_we", 32'(first_we), 32'(v.exp_we));
      if (!v.is_if) exp_mem = v.exp_rdata;
      @(negedge clk);
    end

    // Simultaneous IF fetch and MEM store: MEM first, IF in the mem_ready cycle
    ram_delay = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h40; if_q.push_back(32'h2108_0001);
    mem_wr = 1'b1; mem_addr = 32'h100; mem_wdata = 32'hDEAD_BEEF; mem_q.push_back(exp_mem);
    @(negedge clk);
    check_output("both_mem_en", 32'(ram_en), 32'd1);
    check_output("both_mem_we", 32'(ram_we), 32'd1);
    check_output("both_mem_addr", ram_addr, 32'h100);
    check_output("both_mem_wdata", ram_wdata, 32'hDEAD_BEEF);
    check_output("both_stall_if_1", 32'(stall_if), 32'd1);
    @(negedge clk);
    check_output("both_mem_ready", 32'(mem_ready), 32'd1);
    check_output("both_stall_if_2", 32'(stall_if), 32'd1);
    mem_wr = 1'b0;
    @(negedge clk);
    check_output("both_if_en", 32'(ram_en), 32'd1);
    check_output("both_if_addr", ram_addr, 32'h40);
    check_output("both_if_we", 32'(ram_we), 32'd0);
    check_output("both_stall_if_3", 32'(stall_if), 32'd1);
    @(negedge clk);
    check_output("both_if_ready", 32'(if_ready), 32'd1);
    check_output("both_stall_if_4", 32'(stall_if), 32'd0);
    if_req = 1'b0;
    @(negedge clk);

    // Starvation: four MEM wins while IF waits (IF withdraws each time), then IF wins
    exp_mem = 32'hDEAD_BEEF;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      mem_rd = 1'b1; mem_addr = 32'h100; mem_q.push_back(exp_mem);
      if_req = 1'b1; if_addr = 32'h80;
      @(negedge clk);
      check_output("starve_mem_grant", ram_addr, 32'h100);
      if_req = 1'b0;
      @(negedge clk);
      check_output("starve_mem_ready", 32'(mem_ready), 32'd1);
      mem_rd = 1'b0;
    end
    @(negedge clk);
    mem_rd = 1'b1; mem_addr = 32'h100; mem_q.push_back(exp_mem);
    if_req = 1'b1; if_addr = 32'h80; if_q.push_back(32'hBAD0_0080);
    @(negedge clk);
    check_output("starve_if_grant", ram_addr, 32'h80);
    check_output("starve_if_en", 32'(ram_en), 32'd1);
    @(negedge clk);
    check_output("starve_if_ready", 32'(if_ready), 32'd1);
    if_req = 1'b0;
    @(negedge clk);
    check_output("starve_mem_after_if", ram_addr, 32'h100);
    @(negedge clk);
    check_output("starve_mem_after_ready", 32'(mem_ready), 32'd1);
    mem_rd = 1'b0;
    // Counter cleared by the IF grant: MEM wins the next tie again
    @(negedge clk);
    mem_rd = 1'b1; mem_addr = 32'h100; mem_q.push_back(exp_mem);
    if_req = 1'b1; if_addr = 32'h80;
    @(negedge clk);
    check_output("starve_cleared_mem_wins", ram_addr, 32'h100);
    if_req = 1'b0;
    @(negedge clk);
    check_output("starve_cleared_ready", 32'(mem_ready), 32'd1);
    mem_rd = 1'b0;
    @(negedge clk);

    // mem_rd and mem_wr together act as a store; mem_rdata keeps 0x1234
    v = '{1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h0000_1234, 1'b0};
    apply_stimulus(v, en_cycles, first_addr, first_we, got_ready);
    v = '{1'b0, 1'b1, 1'b1, 32'h500, 32'h0000_9999, 1, 32'h0000_1234, 1'b1};
    apply_stimulus(v, en_cycles, first_addr, first_we, got_ready);
    check_output("rdwr_ram_we", 32'(first_we), 32'd1);
    check_output("rdwr_ready_seen", 32'(got_ready), 32'd1);
    v = '{1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h0000_9999, 1'b0};
    apply_stimulus(v, en_cycles, first_addr, first_we, got_ready);
    exp_mem = 32'h0000_9999;
    @(negedge clk);

    // Slow RAM: latched address/data/strobe hold while requester inputs wander
    ram_delay = 5;
    @(negedge clk);
    mem_wr = 1'b1; mem_addr = 32'h600; mem_wdata = 32'h0BAD_CAFE; mem_q.push_back(exp_mem);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check_output("slow_ram_en", 32'(ram_en), 32'd1);
      check_output("slow_ram_addr", ram_addr, 32'h600);
      check_output("slow_ram_wdata", ram_wdata, 32'h0BAD_CAFE);
      check_output("slow_mem_ready_low", 32'(mem_ready), 32'd0);
      mem_addr  = $urandom;
      mem_wdata = $urandom;
    end
    @(negedge clk);
    check_output("slow_mem_ready", 32'(mem_ready), 32'd1);
    mem_wr = 1'b0;
    repeat (3) @(negedge clk);
    check_output("slow_idle_en", 32'(ram_en), 32'd0);

    // Reset mid BUSY_MEM, then a stale ack after release
    ram_delay = 3;
    @(negedge clk);
    mem_rd = 1'b1; mem_addr = 32'h300;
    @(negedge clk);
    check_output("midrst_busy_en", 32'(ram_en), 32'd1);
    reset = 1'b1;
    #1;
    check_output("midrst_ram_en", 32'(ram_en), 32'd0);
    check_output("midrst_ram_we", 32'(ram_we), 32'd0);
    check_output("midrst_ram_addr", ram_addr, 32'd0);
    check_output("midrst_mem_rdata", mem_rdata, 32'd0);
    check_output("midrst_if_rdata", if_rdata, 32'd0);
    check_output("midrst_mem_ready", 32'(mem_ready), 32'd0);
    @(negedge clk);
    reset  = 1'b0;
    mem_rd = 1'b0;
    @(negedge clk);
    inject_ack = 1'b1;
    @(negedge clk);
    inject_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output("stale_mem_ready", 32'(mem_ready), 32'd0);
      check_output("stale_if_ready", 32'(if_ready), 32'd0);
      check_output("stale_ram_en", 32'(ram_en), 32'd0);
      check_output("stale_mem_rdata", mem_rdata, 32'd0);
    end

    // Recovery access after reset
    v = '{1'b0, 1'b1, 1'b0, 32'h500, 32'h0, 0, 32'h0000_9999, 1'b0};
    apply_stimulus(v, en_cycles, first_addr, first_we, got_ready);
    check_output("recover_ready_seen", 32'(got_ready), 32'd1);
    repeat (3) @(negedge clk);

    check_output("if_queue_empty", 32'(if_q.size()), 32'd0);
    check_output("mem_queue_empty", 32'(mem_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
